rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_seq_pkg.sv | 16 +
 rtl/rst_seq_wdt.sv | 38 +++
 rtl/rst_sequencer.sv | 138 +++++++++++++
 tb/tb_rst_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the staged reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_NUM_RST        = 4;
    localparam int unsigned DEF_HOLD_CYCLES    = 4;
    localparam int unsigned DEF_STAGGER_CYCLES = 2;
    localparam int unsigned DEF_WDT_CYCLES     = 1024;

endpackage

// File: rtl/rst_seq_wdt.sv
// Watchdog for rst_sequencer: counts unkicked RUN cycles and flags expiry
// on the edge where the count would reach WDT_CYCLES-1.
module rst_seq_wdt
    import rst_seq_pkg::*;
#(
    parameter int unsigned WDT_CYCLES = DEF_WDT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic kick_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(WDT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Outside RUN the count is held at zero; it saturates at LIMIT.
    always_comb begin
        cnt_d = '0;
        if (run_i && !kick_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expire_o = run_i && !kick_i && (cnt_q == LIMIT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: holds, then releases NUM_RST resets one by one,
// enables fetch, and supports soft reset. Watchdog is built only under RST_SEQ_WDT_EN.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_RST        = DEF_NUM_RST,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int unsigned WDT_CYCLES     = DEF_WDT_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sw_rst_req_i,
    input  logic               wdt_kick_i,
    output logic [NUM_RST-1:0] rst_no,
    output logic               fetch_enable_o,
    output logic               sw_rst_ack_o,
    output logic               wdt_fired_o,
    output logic               busy_o
);

    // cnt_q holds the edge index relative to the sequence's edge 0; it
    // saturates at the edge where fetch is enabled.
    localparam int unsigned LAST_REL = HOLD_CYCLES + (NUM_RST - 1) * STAGGER_CYCLES;
    localparam int unsigned CNT_MAX  = LAST_REL + 1;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_RST-1:0] rst_n_q, rst_n_d;
    logic               fetch_q, fetch_d;
    logic               ack_q, ack_d;
    logic               fired_q, fired_d;
    logic               sw_pend_q, sw_pend_d;
    logic               busy_q, busy_d;
    logic               run;
    logic               wdt_expire;

    assign run = (state_q == ST_RUN);

`ifdef RST_SEQ_WDT_EN
    rst_seq_wdt #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .run_i    (run),
        .kick_i   (wdt_kick_i),
        .expire_o (wdt_expire)
    );
    assign wdt_fired_o = fired_q;
`else
    logic unused_wdt;
    assign unused_wdt  = wdt_kick_i ^ WDT_CYCLES[0] ^ fired_q;
    assign wdt_expire  = 1'b0;
    assign wdt_fired_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_n_d   = rst_n_q;
        fetch_d   = fetch_q;
        ack_d     = 1'b0;
        fired_d   = fired_q;
        sw_pend_d = sw_pend_q;
        case (state_q)
            ST_ASSERT, ST_RELEASE: begin
                if (cnt_q != CNT_MAX_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                for (int i = 0; i < NUM_RST; i++) begin
                    rst_n_d[i] = (32'(cnt_q) >= HOLD_CYCLES + 32'(i) * STAGGER_CYCLES);
                end
                if (cnt_q == CNT_MAX_C) begin
                    state_d   = ST_RUN;
                    fetch_d   = 1'b1;
                    ack_d     = sw_pend_q;
                    sw_pend_d = 1'b0;
                end else if (32'(cnt_q) >= HOLD_CYCLES) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RUN: begin
                // Watchdog expiry outranks a simultaneous soft request.
                if (wdt_expire) begin
                    state_d   = ST_DRAIN;
                    fetch_d   = 1'b0;
                    fired_d   = 1'b1;
                    sw_pend_d = 1'b0;
                end else if (sw_rst_req_i) begin
                    state_d   = ST_DRAIN;
                    fetch_d   = 1'b0;
                    sw_pend_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                // The drain-exit edge is edge 0 of the restarted sequence.
                state_d = ST_ASSERT;
                rst_n_d = '0;
                cnt_d   = CNT_W'(1);
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase
        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            rst_n_q   <= '0;
            fetch_q   <= 1'b0;
            ack_q     <= 1'b0;
            fired_q   <= 1'b0;
            sw_pend_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_n_q   <= rst_n_d;
            fetch_q   <= fetch_d;
            ack_q     <= ack_d;
            fired_q   <= fired_d;
            sw_pend_q <= sw_pend_d;
            busy_q    <= busy_d;
        end
    end

    assign rst_no         = rst_n_q;
    assign fetch_enable_o = fetch_q;
    assign sw_rst_ack_o   = ack_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus random traffic, every edge
// compared with an edge-arithmetic reference model.
module tb_rst_sequencer;

    localparam int N   = 3;
    localparam int H   = 4;
    localparam int S   = 2;
    localparam int WDT = 16;
    localparam int FETCH_EDGE = H + (N - 1) * S + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic         kick = 1'b0;
    logic [N-1:0] rst_no;
    logic         fetch, ack, fired, busy;

    int checks = 0;
    int errors = 0;

    // Reference model: outputs follow from the distance to the current edge 0.
    int           edge_n = 0;
    int           base = 0;
    bit           have_base = 0;
    bit           drain_pend = 0;
    bit           m_run = 0, m_ack = 0, m_sw = 0, m_fired = 0, m_busy = 1;
    int           last_ref = 0;
    logic [N-1:0] m_rst = '0;

    always #5 clk = ~clk;

    rst_sequencer #(
        .NUM_RST        (N),
        .HOLD_CYCLES    (H),
        .STAGGER_CYCLES (S),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sw_rst_req_i   (req),
        .wdt_kick_i     (kick),
        .rst_no         (rst_no),
        .fetch_enable_o (fetch),
        .sw_rst_ack_o   (ack),
        .wdt_fired_o    (fired),
        .busy_o         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n - 1);
        end
    endtask

    task automatic model_edge(input bit r, input bit q, input bit k);
        int  e;
        int  kk;
        bit  expire;
        bit  accept;
        e = edge_n;
        expire = 0;
        accept = 0;
        if (!r) begin
            have_base = 0; drain_pend = 0; m_run = 0; m_ack = 0; m_sw = 0;
            m_fired = 0; m_busy = 1; m_rst = '0;
        end else begin
            if (!have_base) begin
                have_base = 1;
                base = e;
            end else if (drain_pend) begin
                drain_pend = 0;
                base = e;
            end else if (m_run) begin
`ifdef RST_SEQ_WDT_EN
                if (k) last_ref = e;
                else if (e - last_ref == WDT - 1) expire = 1;
`endif
                accept = expire || q;
            end
            if (accept) begin
                drain_pend = 1;
                m_sw = !expire;
                if (expire) m_fired = 1;
                m_run = 0; m_ack = 0; m_busy = 1;
            end else if (!drain_pend) begin
                kk = e - base;
                for (int i = 0; i < N; i++) m_rst[i] = (kk >= H + i * S);
                m_ack = m_sw && (kk == FETCH_EDGE);
                if (m_ack) m_sw = 0;
                if (!m_run && kk >= FETCH_EDGE) last_ref = e;
                m_run = (kk >= FETCH_EDGE);
                m_busy = !m_run;
            end
        end
    endtask

    task automatic step(input bit r, input bit q, input bit k);
        @(negedge clk);
        rst_n = r; req = q; kick = k;
        @(posedge clk);
        model_edge(r, q, k);
        edge_n++;
        #1;
        check("rst_no", rst_no, m_rst);
        check("fetch", fetch, m_run);
        check("ack", ack, m_ack);
        check("busy", busy, m_busy);
        check("wdt_fired", fired, m_fired);
    endtask

    initial begin
        int  ack_edge;
        bit  req_lvl;
        int  hold_left;

        repeat (3) step(0, 0, 0);
        check("reset_rst_no", rst_no, 0);
        check("reset_fetch", fetch, 0);
        check("reset_busy", busy, 1);
        check("reset_fired", fired, 0);

        // Power-on, with a request pulse during RELEASE that must be ignored.
        for (int e = 0; e <= 9; e++) begin
            step(1, e == 5, 0);
            if (e == 3) check("po_e3", rst_no, 3'b000);
            if (e == 4) check("po_e4", rst_no, 3'b001);
            if (e == 6) check("po_e6", rst_no, 3'b011);
            if (e == 8) check("po_e8", rst_no, 3'b111);
            if (e == 8) check("po_e8_fetch", fetch, 0);
            if (e == 9) check("po_e9_fetch", fetch, 1);
            if (e == 9) check("po_e9_busy", busy, 0);
            if (e >= 5) check("po_no_ack", ack, 0);
        end

        // Soft reset accepted at edge 20.
        for (int e = 10; e <= 31; e++) begin
            step(1, e == 20, 0);
            if (e == 20) check("sw_e20_fetch", fetch, 0);
            if (e == 20) check("sw_e20_rst", rst_no, 3'b111);
            if (e == 21) check("sw_e21_rst", rst_no, 3'b000);
            if (e == 25) check("sw_e25_rst", rst_no, 3'b001);
            if (e == 27) check("sw_e27_rst", rst_no, 3'b011);
            if (e == 29) check("sw_e29_rst", rst_no, 3'b111);
            if (e == 30) check("sw_e30_fetch", fetch, 1);
            if (e == 30) check("sw_e30_ack", ack, 1);
            if (e == 31) check("sw_e31_ack", ack, 0);
        end

        // Request held through the ack restarts on the first RUN edge after it.
        ack_edge = -1;
        for (int j = 0; j < 40 && ack_edge < 0; j++) begin
            step(1, 1, 0);
            if (ack === 1'b1) ack_edge = j;
        end
        check("held_ack_seen", ack_edge >= 0, 1);
        step(1, 1, 0);
        check("held_reaccept_fetch", fetch, 0);
        check("held_reaccept_ack", ack, 0);
        repeat (12) step(1, 0, 0);
        check("held_done_fetch", fetch, 1);

        // Reset asserted mid-release.
        for (int e = 0; e <= 5; e++) step(1, 0, 0);
        step(1, 1, 0);
        for (int e = 0; e <= 5; e++) step(1, 0, 0);
        check("mid_rel_rst", rst_no, 3'b001);
        step(0, 0, 0);
        check("mid_rst_rst_no", rst_no, 3'b000);
        check("mid_rst_busy", busy, 1);
        for (int e = 0; e <= 9; e++) begin
            step(1, 0, 0);
            if (e == 4) check("restart_e4", rst_no, 3'b001);
            if (e == 9) check("restart_e9_fetch", fetch, 1);
        end

`ifdef RST_SEQ_WDT_EN
        // Run entered at local edge 9; no kick means expiry at edge 24.
        for (int e = 10; e <= 24; e++) begin
            step(1, 0, 0);
            if (e == 23) check("wdt_e23_fired", fired, 0);
            if (e == 24) check("wdt_e24_fired", fired, 1);
            if (e == 24) check("wdt_e24_fetch", fetch, 0);
        end
        for (int e = 25; e <= 40; e++) begin
            step(1, 0, 0);
            check("wdt_no_ack", ack, 0);
        end
        for (int j = 0; j < 60; j++) step(1, 0, (j % 10) == 0);
        check("wdt_kicked_fetch", fetch, 1);
        check("wdt_sticky", fired, 1);
`else
        for (int j = 0; j < 40; j++) step(1, 0, 0);
        check("nowdt_fetch", fetch, 1);
        check("nowdt_fired", fired, 0);
`endif

        // Random traffic: held/pulsed requests, sparse kicks, rare resets.
        req_lvl = 0;
        hold_left = 0;
        for (int j = 0; j < 3000; j++) begin
            if (hold_left == 0) begin
                req_lvl = ($urandom_range(0, 5) == 0);
                hold_left = $urandom_range(1, 15);
            end
            hold_left--;
            step($urandom_range(0, 299) != 0, req_lvl, $urandom_range(0, 11) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
